uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
- Parametrised UART receiver, successor to the fixed 8N1 receiver.
- Configurable data width, parity mode and stop-bit count; 3-sample majority vote per bit; parity and framing error reporting.
- Sits between the board serial input pin and the command/byte-stream parser, in a single clock domain.

Parameters:
- CLKS_PER_BIT, 1042, clock cycles per UART bit = f(i_Clock)/baud; legal range >= 8.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY_MODE, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- i_Clock  in  1  system clock.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Rx_Serial  in  1  serial line; idle high; asynchronous to i_Clock.
- o_Rx_DV  out  1  one-cycle pulse: frame complete.
- o_Rx_Data  out  DATA_BITS  received word, LSB first on the line.
- o_Parity_Err  out  1  parity mismatch for the frame flagged by o_Rx_DV; always 0 when PARITY_MODE=0.
- o_Frame_Err  out  1  at least one stop bit sampled 0 for the frame flagged by o_Rx_DV.
- o_Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: one clock, asynchronous active-high. On assertion, the FSM goes to IDLE and the counters clear.
  - Reset values: o_Rx_DV=0, o_Rx_Data=0, o_Parity_Err=0, o_Frame_Err=0, o_Busy=0, synchroniser flops=1.
  - Reset mid-frame abandons the partial frame; no o_Rx_DV is issued for it.
- Input conditioning: 2-flop synchroniser; all logic uses the synchronised line (rx_s).
- Bit counter: counts 0..CLKS_PER_BIT-1.
- Majority vote: rx_s is sampled at counts CLKS_PER_BIT-3, -2 and -1. Bit value = majority of the 3 samples; it is decided at count CLKS_PER_BIT-1.
- States:
  - IDLE: counters clear. rx_s=0 -> START.
  - START: counter runs to CLKS_PER_BIT/2 (integer division); checks rx_s there.
    - rx_s=0: counter -> 0, go to DATA.
    - rx_s=1 (glitch): go to IDLE; no outputs change.
  - DATA: samples DATA_BITS bits, each decided at count CLKS_PER_BIT-1, shifted in LSB first. After the last bit: PARITY if PARITY_MODE!=0, else STOP.
  - PARITY: samples one bit.
    - Expected bit = XOR of the data bits (even) or its inverse (odd).
    - Mismatch sets the internal parity-error flag.
  - STOP: samples STOP_BITS bits; any 0 sets the internal frame-error flag. After the last stop sample, go to CLEANUP.
  - CLEANUP: one cycle.
    - o_Rx_DV=1; o_Rx_Data, o_Parity_Err and o_Frame_Err are loaded in the same cycle.
    - Next state: IDLE if rx_s=1, else WAIT_HIGH.
  - WAIT_HIGH: stays until rx_s=1, then IDLE. This prevents a break or held-low line from being taken as a new start bit.
- Output holding: o_Rx_Data and the error outputs hold until the next CLEANUP. A frame with errors is still delivered with o_Rx_DV.
- Latency: o_Rx_DV rises exactly 1 cycle after the final stop-bit decision cycle. Total from the i_Rx_Serial falling edge = 2 (synchroniser) + 1 + CLKS_PER_BIT/2 + (DATA_BITS + P + STOP_BITS)·CLKS_PER_BIT + 1 cycles, where P = 1 if parity is enabled, else 0.
- Minimum gap: a start edge arriving during CLEANUP is seen by IDLE on the following cycle; no minimum gap beyond the stop bit(s) is required.
- Unsupported values: out-of-range parameter values are unsupported; the implementation raises a simulation $error at elaboration.

Optional Feature:
- Macro: UART_RX_BREAK_DETECT_EN.
- Defined:
  - Adds port o_Break (out, 1, reset 0).
  - A frame whose start, data, parity (if any) and first stop bit all decide 0 is a break. For a break, CLEANUP pulses o_Break for 1 cycle instead of o_Rx_DV; o_Rx_Data and the error outputs keep their previous values.
  - The FSM then waits in WAIT_HIGH as usual.
- Undefined: o_Break port is absent; the same frame is delivered as data 0 with o_Rx_DV=1 and o_Frame_Err=1.

Test Plan:
- CLKS_PER_BIT=16, 8N1, send 0xA5 then 0x3C back-to-back -> two o_Rx_DV pulses; data 0xA5 then 0x3C; both error flags 0; second byte not lost.
- DATA_BITS=7, PARITY_MODE=2 (even): send 0x41 with correct parity 0, then 0x41 with parity 1 -> first o_Parity_Err=0, second o_Parity_Err=1; o_Rx_Data=0x41 both times.
- STOP_BITS=2: send 0x55 with the second stop bit driven 0 for a full bit -> o_Rx_DV with o_Frame_Err=1. Hold the line low 3 more bit times -> no new frame until the line returns high.
- 8N1: 3-cycle low glitch on idle line -> no o_Rx_DV, FSM back in IDLE. Invert one of the 3 samples in a data bit -> bit value unaffected (majority).
- Assert i_Reset mid-DATA, release, then send 0x81 -> no pulse for the aborted frame; next o_Rx_DV gives 0x81; all outputs 0 while reset is asserted.
- With UART_RX_BREAK_DETECT_EN: line low for 12 bit times -> one o_Break pulse, no o_Rx_DV. Without the macro -> o_Rx_DV with data 0x00 and o_Frame_Err=1.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver: 5..9 data bits, none/odd/even parity, 1-2 stop bits
// Optional break detection (o_Break) when UART_RX_BREAK_DETECT_EN is defined.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 1042,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Data,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic                 o_Break,
`endif
    output logic                 o_Busy
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(CLKS_PER_BIT - 2);
    localparam logic [CW-1:0] CNT_S0   = CW'(CLKS_PER_BIT - 3);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 8) begin : g_bad_clks
        $error("uart_rx_cfg: CLKS_PER_BIT must be >= 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_rx_cfg: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, CLEANUP, WAIT_HIGH
    } state_t;

    state_t               state, state_n;
    logic                 sync1, rx_s;
    logic [CW-1:0]        cnt, cnt_n;
    logic [3:0]           idx, idx_n;
    logic                 s0, s0_n, s1, s1_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 perr_q, perr_n, ferr_q, ferr_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 perr_out_n, ferr_out_n;
    logic                 bit_val, at_last, exp_par;
    logic                 brk_now, brk_hold;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= i_Rx_Serial;
            rx_s  <= sync1;
        end
    end

    // The third vote is the live sample in the decision cycle.
    assign bit_val = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign at_last = (cnt == CNT_LAST);
    assign exp_par = (^shreg) ^ (PARITY_MODE == 1);

`ifdef UART_RX_BREAK_DETECT_EN
    logic zero_q;

    // Stays set while every decided bit up to and including the first stop bit is 0.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            zero_q <= 1'b1;
        end else if (state == IDLE) begin
            zero_q <= 1'b1;
        end else if (at_last && (state == DATA || state == PARITY ||
                                 (state == STOP && idx == 4'd0))) begin
            zero_q <= zero_q & ~bit_val;
        end
    end

    assign brk_now  = (idx == 4'd0) ? (zero_q & ~bit_val) : zero_q;
    assign brk_hold = zero_q;
    assign o_Break  = (state == CLEANUP) && zero_q;
`else
    assign brk_now  = 1'b0;
    assign brk_hold = 1'b0;
`endif

    assign o_Rx_DV = (state == CLEANUP) && !brk_hold;
    assign o_Busy  = (state != IDLE);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            s0           <= 1'b1;
            s1           <= 1'b1;
            shreg        <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            o_Rx_Data    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            idx          <= idx_n;
            s0           <= s0_n;
            s1           <= s1_n;
            shreg        <= shreg_n;
            perr_q       <= perr_n;
            ferr_q       <= ferr_n;
            o_Rx_Data    <= data_n;
            o_Parity_Err <= perr_out_n;
            o_Frame_Err  <= ferr_out_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        idx_n      = idx;
        s0_n       = s0;
        s1_n       = s1;
        shreg_n    = shreg;
        perr_n     = perr_q;
        ferr_n     = ferr_q;
        data_n     = o_Rx_Data;
        perr_out_n = o_Parity_Err;
        ferr_out_n = o_Frame_Err;

        if (state == DATA || state == PARITY || state == STOP) begin
            if (cnt == CNT_S0) s0_n = rx_s;
            if (cnt == CNT_S1) s1_n = rx_s;
            cnt_n = at_last ? '0 : cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                cnt_n  = '0;
                idx_n  = '0;
                perr_n = 1'b0;
                ferr_n = 1'b0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (at_last) begin
                    shreg_n = {bit_val, shreg[DATA_BITS-1:1]};
                    if (idx == LAST_DATA) begin
                        idx_n   = '0;
                        state_n = (PARITY_MODE != 0) ? PARITY : STOP;
                    end else begin
                        idx_n = idx + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (at_last) begin
                    perr_n  = (bit_val != exp_par);
                    state_n = STOP;
                end
            end
            STOP: begin
                if (at_last) begin
                    if (!bit_val) ferr_n = 1'b1;
                    if (idx == LAST_STOP) begin
                        state_n = CLEANUP;
                        // A break leaves the previously delivered word and flags in place.
                        if (!brk_now) begin
                            data_n     = shreg;
                            perr_out_n = perr_q;
                            ferr_out_n = ferr_q | ~bit_val;
                        end
                    end else begin
                        idx_n = idx + 4'd1;
                    end
                end
            end
            CLEANUP: begin
                state_n = rx_s ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - self-checking bench for uart_rx_cfg (8N1, 7E1 and 8N2 instances)
module tb_uart_rx_cfg;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] line;
    logic [2:0] dv, perr, ferr, busy;
    logic [7:0] data0, data2;
    logic [6:0] data1;
`ifdef UART_RX_BREAK_DETECT_EN
    logic [2:0] brk;
`endif

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(line[0]), .o_Rx_DV(dv[0]),
        .o_Rx_Data(data0), .o_Parity_Err(perr[0]), .o_Frame_Err(ferr[0]),
`ifdef UART_RX_BREAK_DETECT_EN
        .o_Break(brk[0]),
`endif
        .o_Busy(busy[0]));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1)) u1 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(line[1]), .o_Rx_DV(dv[1]),
        .o_Rx_Data(data1), .o_Parity_Err(perr[1]), .o_Frame_Err(ferr[1]),
`ifdef UART_RX_BREAK_DETECT_EN
        .o_Break(brk[1]),
`endif
        .o_Busy(busy[1]));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u2 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(line[2]), .o_Rx_DV(dv[2]),
        .o_Rx_Data(data2), .o_Parity_Err(perr[2]), .o_Frame_Err(ferr[2]),
`ifdef UART_RX_BREAK_DETECT_EN
        .o_Break(brk[2]),
`endif
        .o_Busy(busy[2]));

    function automatic int nbits(input int k);
        return (k == 1) ? 7 : 8;
    endfunction
    function automatic int pmode(input int k);
        return (k == 1) ? 2 : 0;
    endfunction
    function automatic int nstop(input int k);
        return (k == 2) ? 2 : 1;
    endfunction
    function automatic int latency(input int k);
        return 4 + CPB / 2 + (nbits(k) + ((pmode(k) != 0) ? 1 : 0) + nstop(k)) * CPB;
    endfunction

    // Frame rules: word masked to the width, parity judged by total count of ones, any 0 stop is a frame error.
    function automatic logic [10:0] model(input int k, input logic [8:0] d, input logic pb, input logic [1:0] st);
        logic [8:0] m;
        int ones;
        logic pe, fe;
        m = d & ((9'd1 << nbits(k)) - 9'd1);
        ones = $countones(m) + int'(pb);
        pe = 1'b0;
        if (pmode(k) == 2) pe = (ones % 2) != 0;
        else if (pmode(k) == 1) pe = (ones % 2) == 0;
        fe = 1'b0;
        for (int i = 0; i < nstop(k); i++) if (!st[i]) fe = 1'b1;
        return {pe, fe, m};
    endfunction

    typedef struct {
        int         k;
        logic [8:0] d;
        logic       pe;
        logic       fe;
        int         t;
    } ev_t;

    ev_t evq[$];
    ev_t mon_e;
    int  cyc = 0;
    int  brk_cnt = 0;
    int  start_cyc[3];
    int  checks = 0;
    int  errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (dv[k]) begin
                mon_e.k  = k;
                mon_e.d  = (k == 0) ? {1'b0, data0} : (k == 1) ? {2'b0, data1} : {1'b0, data2};
                mon_e.pe = perr[k];
                mon_e.fe = ferr[k];
                mon_e.t  = cyc;
                evq.push_back(mon_e);
            end
        end
`ifdef UART_RX_BREAK_DETECT_EN
        if (brk != 3'b000) brk_cnt = brk_cnt + 1;
`endif
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic hold(input int k, input logic v, input int n);
        line[k] = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int k, input logic [8:0] d, input logic pb, input logic [1:0] st, input int glitch);
        start_cyc[k] = cyc;
        hold(k, 1'b0, CPB);
        for (int i = 0; i < nbits(k); i++) begin
            if (i == glitch) begin
                hold(k, d[i], CPB / 2);
                hold(k, ~d[i], 1);
                hold(k, d[i], CPB / 2 - 1);
            end else begin
                hold(k, d[i], CPB);
            end
        end
        if (pmode(k) != 0) hold(k, pb, CPB);
        for (int i = 0; i < nstop(k); i++) hold(k, st[i], CPB);
        line[k] = 1'b1;
    endtask

    task automatic expect_frame(input string tag, input int k, input logic [10:0] exp, input bit chk_lat);
        int  n;
        ev_t e;
        n = 0;
        while (evq.size() == 0 && n < 4 * CPB) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (evq.size() == 0) begin
            errors++;
            $display("FAIL %s present: no o_Rx_DV within %0d cycles, expected one frame", tag, 4 * CPB);
        end else begin
            e = evq.pop_front();
            chk({tag, " dut"}, e.k, k);
            chk({tag, " data"}, e.d, exp[8:0]);
            chk({tag, " parity_err"}, e.pe, exp[10]);
            chk({tag, " frame_err"}, e.fe, exp[9]);
            if (chk_lat) chk({tag, " latency"}, e.t - start_cyc[k], latency(k));
        end
    endtask

    typedef struct {
        int         k;
        logic [8:0] d;
        logic       pb;
        logic [1:0] st;
        int         gap;
        logic [8:0] ed;
        logic       epe;
        logic       efe;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] exp;
        int          k, gap;
        logic [8:0]  d;
        logic        pb;
        logic [1:0]  st;

        tbl[0]  = '{0, 9'h0A5, 1'b0, 2'b11, 0,   9'h0A5, 1'b0, 1'b0};
        tbl[1]  = '{0, 9'h03C, 1'b0, 2'b11, CPB, 9'h03C, 1'b0, 1'b0};
        tbl[2]  = '{1, 9'h041, 1'b0, 2'b11, 0,   9'h041, 1'b0, 1'b0};
        tbl[3]  = '{1, 9'h041, 1'b1, 2'b11, CPB, 9'h041, 1'b1, 1'b0};
        tbl[4]  = '{1, 9'h07F, 1'b1, 2'b11, 0,   9'h07F, 1'b0, 1'b0};
        tbl[5]  = '{1, 9'h02A, 1'b0, 2'b11, CPB, 9'h02A, 1'b1, 1'b0};
        tbl[6]  = '{2, 9'h081, 1'b0, 2'b11, 0,   9'h081, 1'b0, 1'b0};
        tbl[7]  = '{2, 9'h055, 1'b0, 2'b10, CPB, 9'h055, 1'b0, 1'b1};
        tbl[8]  = '{0, 9'h0FF, 1'b0, 2'b01, 0,   9'h0FF, 1'b0, 1'b0};
        tbl[9]  = '{0, 9'h001, 1'b0, 2'b10, CPB, 9'h001, 1'b0, 1'b1};
        tbl[10] = '{0, 9'h080, 1'b0, 2'b11, 0,   9'h080, 1'b0, 1'b0};
        tbl[11] = '{1, 9'h1FF, 1'b0, 2'b11, CPB, 9'h07F, 1'b1, 1'b0};

        rst  = 1'b0;
        line = 3'b111;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset dv", {29'd0, dv}, 0);
        chk("reset busy", {29'd0, busy}, 0);
        chk("reset parity_err", {29'd0, perr}, 0);
        chk("reset frame_err", {29'd0, ferr}, 0);
        chk("reset data", {data0, data1, data2}, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            send_frame(tbl[i].k, tbl[i].d, tbl[i].pb, tbl[i].st, -1);
            expect_frame($sformatf("vec%0d", i), tbl[i].k, {tbl[i].epe, tbl[i].efe, tbl[i].ed}, 1'b1);
            if (tbl[i].gap > 0) hold(tbl[i].k, 1'b1, tbl[i].gap);
        end

        hold(0, 1'b0, 3);
        hold(0, 1'b1, 3 * CPB);
        chk("glitch no frame", evq.size(), 0);
        chk("glitch back to idle", busy[0], 0);

        send_frame(0, 9'h05A, 1'b0, 2'b11, 3);
        expect_frame("vote bit3", 0, 11'h05A, 1'b1);
        send_frame(0, 9'h05A, 1'b0, 2'b11, 0);
        expect_frame("vote bit0", 0, 11'h05A, 1'b1);
        hold(0, 1'b1, CPB);

        hold(0, 1'b0, CPB);
        hold(0, 1'b1, 3 * CPB);
        chk("busy mid data", busy[0], 1);
        rst = 1'b1;
        line[0] = 1'b1;
        #2;
        chk("mid reset dv", {29'd0, dv}, 0);
        chk("mid reset busy", {29'd0, busy}, 0);
        chk("mid reset flags", {perr, ferr}, 0);
        chk("mid reset data", {data0, data1, data2}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        hold(0, 1'b1, 10 * CPB);
        chk("aborted frame silent", evq.size(), 0);
        send_frame(0, 9'h081, 1'b0, 2'b11, -1);
        expect_frame("after reset", 0, 11'h081, 1'b1);
        hold(0, 1'b1, CPB);

        send_frame(2, 9'h055, 1'b0, 2'b01, -1);
        hold(2, 1'b0, 3 * CPB);
        expect_frame("stop2 low", 2, 11'h255, 1'b1);
        chk("held low busy", busy[2], 1);
        chk("held low no new frame", evq.size(), 0);
        hold(2, 1'b1, 4);
        chk("line high idle", busy[2], 0);
        send_frame(2, 9'h03C, 1'b0, 2'b11, -1);
        expect_frame("after held low", 2, 11'h03C, 1'b1);

        start_cyc[0] = cyc;
        hold(0, 1'b0, 12 * CPB);
`ifdef UART_RX_BREAK_DETECT_EN
        chk("break pulses", brk_cnt, 1);
        chk("break no dv", evq.size(), 0);
        chk("break keeps data", data0, 8'h81);
        chk("break keeps frame_err", ferr[0], 0);
`else
        expect_frame("break as data", 0, 11'h200, 1'b1);
`endif
        chk("break waits high", busy[0], 1);
        hold(0, 1'b1, 4);
        chk("break released", busy[0], 0);
        hold(0, 1'b1, CPB);

        for (int r = 0; r < 40; r++) begin
            k  = $urandom_range(0, 2);
            d  = 9'($urandom);
            if ((d & ((9'd1 << nbits(k)) - 9'd1)) == 9'd0) d[0] = 1'b1;
            pb = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            exp = model(k, d, pb, st);
            gap = exp[9] ? CPB : $urandom_range(0, 2);
            send_frame(k, d, pb, st, -1);
            expect_frame($sformatf("rand%0d", r), k, exp, 1'b0);
            if (gap > 0) hold(k, 1'b1, gap);
        end
        hold(0, 1'b1, 2 * CPB);
        chk("no spurious frames", evq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
